// File: rtl/fifo_read_ctrl_pkg.sv
// Shared definitions for the FIFO read controller: FSM encoding and default widths.
package fifo_read_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_DATA_W     = 10;
    localparam int DEF_SKID_DEPTH = 2;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry register FIFO that catches the word arriving one cycle after a FIFO read.
module skid_buffer
    import fifo_read_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] tail;

    // head is the oldest entry; it keeps its last value once the buffer drains
    always_ff @(posedge clk) begin
        if (!reset) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= push_data;
                    else             tail <= push_data;
                    if (occ != 2'd2) occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2) head <= tail;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Drains the data FIFO (1-cycle read latency) into a valid/ready stream via a 2-entry skid.
module fifo_read_ctrl
    import fifo_read_ctrl_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SKID_DEPTH = DEF_SKID_DEPTH,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic              fifo_error,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  word_cnt
);

    state_t     state, state_nxt;
    logic       inflight;
    logic [1:0] occ;
    logic       pop;
    logic [2:0] committed;
    logic       overflow;

    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign busy      = (state != IDLE);

    // Entries that will be occupied after this edge if no new read is issued
    assign committed  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = reset && (state == RUN) && !fifo_empty
                        && (32'(committed) < SKID_DEPTH);
    assign overflow   = inflight && (32'(occ) == SKID_DEPTH) && !pop;

    skid_buffer #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .head      (out_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            inflight <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_rd_en;
            err      <= err | fifo_error | overflow;
            if (pop) word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    // A read issued in the same cycle enable falls still counts as outstanding work
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = RUN;
            RUN: begin
                if (!enable) begin
                    if (inflight || fifo_rd_en || (occ != 2'd0)) state_nxt = DRAIN;
                    else                                         state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (enable)                               state_nxt = RUN;
                else if (!inflight && (occ == 2'd0))      state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Downstream consumer stage of the 8-entry data FIFO. Pops words using the FIFO's 1-cycle registered read latency and presents them on a valid/ready output stream. A small skid buffer absorbs the in-flight read word, so the block never underflows the FIFO and never drops a word under backpressure. Full throughput of one word per clock is sustained while the consumer is ready.

Parameters:
DATA_W, 10, word width; matches the FIFO data width.
SKID_DEPTH, 2, skid buffer entries; fixed at 2 and must be at least 2.
CNT_W, 16, width of the delivered-word counter.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-low reset.
enable  in  1  1 = drain the FIFO; 0 = stop issuing reads.
fifo_empty  in  1  FIFO empty flag.
fifo_error  in  1  FIFO error flag (count overflow).
fifo_data  in  DATA_W  FIFO data_out; valid 1 cycle after fifo_rd_en.
fifo_rd_en  out  1  read enable to the FIFO (combinational).
out_valid  out  1  output word valid.
out_data  out  DATA_W  output word (skid buffer head).
out_ready  in  1  consumer accepts the word when out_valid && out_ready (pop).
busy  out  1  state != IDLE.
err  out  1  sticky error flag.
word_cnt  out  CNT_W  count of popped words; wraps modulo 2^CNT_W.

Behaviour:
- Reset: while reset == 0 at a clock edge:
  - state = IDLE; skid occupancy = 0; inflight = 0.
  - out_valid = 0, out_data = 0, err = 0, word_cnt = 0, busy = 0, fifo_rd_en = 0.
  - Reset mid-operation discards all buffered and in-flight words.
- Internal regs: inflight (1 bit) = fifo_rd_en registered; occ (0..2) = skid occupancy.
- Read issue (combinational): fifo_rd_en = (state == RUN) && !fifo_empty && (occ + inflight - pop) < SKID_DEPTH.
  - fifo_rd_en is never asserted while fifo_empty = 1, which guarantees no FIFO underflow.
  - The out_ready -> fifo_rd_en path is combinational by design.
- Capture: when inflight = 1, fifo_data is written to the skid tail on that edge.
  - Push and pop on the same edge: occ is unchanged and order is preserved (FIFO order, head = oldest).
- Output:
  - out_valid = (occ != 0).
  - out_data = head entry, held stable while out_valid && !out_ready.
  - out_data = 0 when empty after reset; otherwise the last value is held.
- Throughput: with out_ready held at 1 and the FIFO non-empty, one word is delivered per clock. First-word latency from the RUN entry edge is 2 clocks.
- word_cnt increments by 1 on each pop.
- err: set when fifo_error = 1, or when inflight = 1 && occ == SKID_DEPTH && !pop (internal overflow; must never occur). Cleared only by reset.
- State machine:
  - IDLE -> RUN: enable = 1.
  - RUN -> DRAIN: enable = 0 and (inflight || occ != 0). Reads stop immediately.
  - RUN -> IDLE: enable = 0 and nothing buffered or in flight.
  - DRAIN -> IDLE: inflight = 0 and occ = 0. Buffered words are still delivered to the consumer.
  - DRAIN -> RUN: enable = 1 again. Allowed at any time.
- Boundaries:
  - FIFO holding 1 word: one read is issued; the next cycle fifo_empty = 1 and no further read is issued.
  - out_ready low for many cycles: occ saturates at 2 and reads halt. The FIFO fills; its full/almost_full flags are the upstream producer's concern.
  - Simultaneous enable fall and read issue: the issued read completes and its word is delivered during DRAIN.

Decomposition:
- Shared package/include: state encodings (IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2) and the default DATA_W = 10.
- Sub-module: skid_buffer (2-entry register FIFO with push, pop, occ, head). The FSM and read-issue logic remain in fifo_read_ctrl.

Test Plan:
- Reset, then 5 words (0x001..0x005) in the FIFO; enable = 1, out_ready = 1 -> fifo_rd_en high for 5 consecutive cycles; out_data 0x001..0x005 on consecutive cycles starting 2 clocks after RUN; word_cnt = 5; busy returns to 0 after enable drops.
- 8 words queued, out_ready = 0 -> exactly 2 reads issued; occ = 2; out_data = 0x001 held stable. Raise out_ready -> remaining 6 words follow in order with no gaps and no duplicates.
- FIFO with 1 word; enable = 1 -> single fifo_rd_en pulse; fifo_rd_en never asserted while fifo_empty = 1 (assertion checked every cycle).
- Drop enable the same cycle a read issues -> state passes through DRAIN; the in-flight word is delivered; then IDLE; no further fifo_rd_en.
- Pulse fifo_error for 1 cycle -> err = 1 and stays 1 until reset; reset asserted mid-stream -> all outputs return to reset values on the next edge.
- Random out_ready (50%) with 200 words -> output sequence equals input sequence; err = 0; word_cnt = 200.
